dcache_mem_responder: RTL

- Memory-side responder for the load/store request FSM that sits between the DTLB and the data cache.
- Accepts one translated load or store request at a time and holds it for a fixed latency.
- Answers loads with ld_resp_valid_o plus read data, and stores with a st_resp_gnt_o pulse.
- Backed by a local byte-enabled word array; used as the dcache stand-in for core bring-up and as the target model for core-side verification.

---
 rtl/dcache_mem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_responder
// Brief    : Memory-side responder for the load/store request FSM. Accepts
//            one load or store at a time, holds it for a fixed latency, then
//            answers loads with read data and stores with a grant pulse.
//            Backed by a byte-enabled word array (not cleared by reset).
// Ports    : clk, rst             - clock, synchronous active-high reset
//            mem_req_valid_i      - request strobe
//            is_load_i/is_store_i - request type (exactly one must be set)
//            kill_mem_op_i        - squash the outstanding request (IDLE/WAIT)
//            req_addr_i           - physical byte address
//            req_wdata_i/req_be_i - store data / byte enables
//            ld_resp_valid_o      - one-cycle load response pulse
//            ld_resp_data_o       - load data, 0 when no response
//            st_resp_gnt_o        - one-cycle store grant pulse
//            busy_o               - request outstanding
//            req_err_o            - malformed request pulse
// Options  : `define DCACHE_RESP_RANDOM_STALL_EN adds 0-3 LFSR-driven stall
//            cycles to every accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 256,
    parameter int LD_LATENCY = 2,
    parameter int ST_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_req_valid_i,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic                kill_mem_op_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                ld_resp_valid_o,
    output logic [DATA_W-1:0]   ld_resp_data_o,
    output logic                st_resp_gnt_o,
    output logic                busy_o,
    output logic                req_err_o
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_BE_W);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for a 15-cycle latency plus 3 stall cycles.
    localparam int c_CNT_W = 5;

    localparam logic [c_CNT_W-1:0] c_LD_CNT = c_CNT_W'(LD_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_ST_CNT = c_CNT_W'(ST_LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_BE_W-1:0]  r_be;
    logic               r_is_load;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_type_ok;
    logic               w_accept;
    logic               w_malformed;
    logic               w_ld_resp;
    logic               w_st_resp;
    logic               w_st_commit;
    logic               w_force_wait;
    logic [c_CNT_W-1:0] w_base_cnt;
    logic [c_CNT_W-1:0] w_cnt_init;
    logic [c_IDX_W-1:0] w_req_idx;
    logic               w_unused_addr;

    // Byte-offset bits and bits above the word index are deliberately
    // ignored, so addresses alias modulo DEPTH words.
    assign w_req_idx     = req_addr_i[c_OFF_W +: c_IDX_W];
    assign w_unused_addr = ^req_addr_i;

    assign w_type_ok   = is_load_i ^ is_store_i;
    assign w_accept    = (r_state == c_IDLE) && mem_req_valid_i && !kill_mem_op_i && w_type_ok;
    assign w_malformed = (r_state == c_IDLE) && mem_req_valid_i && !kill_mem_op_i && !w_type_ok;
    assign w_base_cnt  = is_load_i ? c_LD_CNT : c_ST_CNT;

`ifdef DCACHE_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_cnt_init   = w_base_cnt + c_CNT_W'(r_lfsr[1:0]);
    assign w_force_wait = 1'b1;
`else
    assign w_cnt_init   = w_base_cnt;
    assign w_force_wait = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = w_cnt_init;
                    w_state_nxt = (w_force_wait || (w_cnt_init != '0)) ? c_WAIT : c_RESP;
                end
            end
            c_WAIT: begin
                if (kill_mem_op_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_IDLE;
                end else if (r_cnt <= c_CNT_W'(1)) begin
                    // Last waiting cycle; a zero count only occurs when the
                    // stall option forces WAIT with nothing to add.
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            c_RESP: begin
                // Committed: kill is not looked at here.
                w_cnt_nxt   = '0;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_is_load <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx     <= w_req_idx;
                r_wdata   <= req_wdata_i;
                r_be      <= req_be_i;
                r_is_load <= is_load_i;
            end
        end
    end

    assign w_ld_resp = (r_state == c_RESP) && r_is_load;
    assign w_st_resp = (r_state == c_RESP) && !r_is_load;
    // A reset landing in the RESP cycle must drop the pending store.
    assign w_st_commit = w_st_resp && !rst;

    always_ff @(posedge clk) begin
        if (w_st_commit) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ld_resp_valid_o = w_ld_resp;
    assign ld_resp_data_o  = w_ld_resp ? r_mem[r_idx] : '0;
    assign st_resp_gnt_o   = w_st_resp;
    assign busy_o          = (r_state != c_IDLE);
    assign req_err_o       = w_malformed;

endmodule
`default_nettype wire
